// File: rtl/speck_cipher_core_pkg.sv
// Shared types, constants and rotation-amount helpers for the Speck cipher core.
package speck_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  function automatic int unsigned speck_alpha(input int unsigned w);
    return (w == 16) ? 7 : 8;
  endfunction

  function automatic int unsigned speck_beta(input int unsigned w);
    return (w == 16) ? 2 : 3;
  endfunction

endpackage

// File: rtl/speck_cipher_core_if.sv
// Block handshake bus: input block on one valid/ready pair, result on another.
interface speck_cipher_core_if #(
  parameter int unsigned W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_x;
  logic [W-1:0] out_y;

  modport master (
    output in_valid, mode, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_x, out_y
  );

  modport slave (
    input  in_valid, mode, in_x, in_y, out_ready,
    output in_ready, out_valid, out_x, out_y
  );
endinterface

// File: rtl/speck_cipher_core_round.sv
// One combinational Speck round, encrypt or decrypt selected by mode_i.
module speck_round
  import speck_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [W-1:0] k_i,
  input  logic         mode_i,
  output logic [W-1:0] x_o,
  output logic [W-1:0] y_o
);
  localparam int unsigned ALPHA = speck_alpha(W);
  localparam int unsigned BETA  = speck_beta(W);

  function automatic logic [W-1:0] ror(input logic [W-1:0] v, input int unsigned s);
    return (v >> s) | (v << (W - s));
  endfunction

  function automatic logic [W-1:0] rol(input logic [W-1:0] v, input int unsigned s);
    return (v << s) | (v >> (W - s));
  endfunction

  logic [W-1:0] x_enc, y_enc, x_dec, y_dec;

  // Decrypt undoes the encrypt steps in reverse order.
  assign x_enc = (ror(x_i, ALPHA) + y_i) ^ k_i;
  assign y_enc = rol(y_i, BETA) ^ x_enc;
  assign y_dec = ror(x_i ^ y_i, BETA);
  assign x_dec = rol((x_i ^ k_i) - y_dec, ALPHA);

  assign x_o = (mode_i == MODE_DEC) ? x_dec : x_enc;
  assign y_o = (mode_i == MODE_DEC) ? y_dec : y_enc;
endmodule

// File: rtl/speck_cipher_core.sv
// Iterative Speck cipher core: RPC chained rounds per clock, IDLE/RUN/DONE control.
module speck_cipher_core
  import speck_pkg::*;
#(
  parameter int unsigned W      = 32,
  parameter int unsigned ROUNDS = 27,
  parameter int unsigned RPC    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  speck_cipher_core_if.slave    bus,
  input  logic [W*ROUNDS-1:0]   rk_flat_i,
  output logic                  busy_o
);
  localparam int unsigned NG   = ROUNDS / RPC;
  localparam int unsigned CW   = (NG > 1) ? $clog2(NG) : 1;
  localparam int unsigned IDXW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  if ((RPC == 0) || (ROUNDS % RPC != 0)) begin : g_bad_rpc
    $error("speck_cipher_core: ROUNDS must be a multiple of RPC");
  end
  if (!((W == 16) || (W == 24) || (W == 32) || (W == 48) || (W == 64))) begin : g_bad_w
    $error("speck_cipher_core: unsupported word width");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  x_q, x_d, y_q, y_d;
  logic          mode_q, mode_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic [W-1:0]  x_next, y_next;

  logic [W-1:0] rk [ROUNDS];
  for (genvar g = 0; g < ROUNDS; g++) begin : g_rk
    assign rk[g] = rk_flat_i[g*W +: W];
  end

  // Round chain; decrypt walks the key list from the top end down.
  for (genvar j = 0; j < RPC; j++) begin : g_stage
    logic [IDXW-1:0] idx;
    logic [W-1:0]    key, x_in, y_in, x_out, y_out;

    assign idx = IDXW'(cnt_q) * IDXW'(RPC) + IDXW'(j);
    assign key = (mode_q == MODE_DEC) ? rk[IDXW'(ROUNDS - 1) - idx] : rk[idx];

    if (j == 0) begin : g_first
      assign x_in = x_q;
      assign y_in = y_q;
    end else begin : g_next
      assign x_in = g_stage[j-1].x_out;
      assign y_in = g_stage[j-1].y_out;
    end

    speck_round #(.W(W)) u_round (
      .x_i    (x_in),
      .y_i    (y_in),
      .k_i    (key),
      .mode_i (mode_q),
      .x_o    (x_out),
      .y_o    (y_out)
    );
  end

  assign x_next = g_stage[RPC-1].x_out;
  assign y_next = g_stage[RPC-1].y_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      mode_q      <= MODE_ENC;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      mode_q      <= mode_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next state and datapath; status outputs are registered from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          x_d     = bus.in_x;
          y_d     = bus.in_y;
          mode_d  = bus.mode;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        x_d   = x_next;
        y_d   = y_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NG - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_x     = x_q;
  assign bus.out_y     = y_q;
  assign busy_o        = busy_q;
endmodule

// File: tb/tb_speck_cipher_core.sv
// Directed and model-checked bench for three speck_cipher_core configurations.
module tb_speck_cipher_core;
  import speck_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-DUT drive/observe: 0 = W32/RPC1, 1 = W32/RPC3, 2 = W16/R22
  logic        iv [3];
  logic        md [3];
  logic        ordy [3];
  logic [31:0] ix [3];
  logic [31:0] iy [3];
  logic        ir [3];
  logic        ov [3];
  logic        bz [3];
  logic [31:0] ox [3];
  logic [31:0] oy [3];

  logic [31:0]        rk32 [27];
  logic [15:0]        rk16 [22];
  logic [32*27-1:0]   rk32_flat;
  logic [16*22-1:0]   rk16_flat;
  logic [63:0]        ks_rk [27];

  for (genvar g = 0; g < 27; g++) begin : g_rk32
    assign rk32_flat[g*32 +: 32] = rk32[g];
  end
  for (genvar g = 0; g < 22; g++) begin : g_rk16
    assign rk16_flat[g*16 +: 16] = rk16[g];
  end

  speck_cipher_core_if #(.W(32)) if0 ();
  speck_cipher_core_if #(.W(32)) if1 ();
  speck_cipher_core_if #(.W(16)) if2 ();

  assign if0.in_valid = iv[0];  assign if0.mode = md[0];  assign if0.out_ready = ordy[0];
  assign if0.in_x = ix[0];      assign if0.in_y = iy[0];
  assign ir[0] = if0.in_ready;  assign ov[0] = if0.out_valid;
  assign ox[0] = if0.out_x;     assign oy[0] = if0.out_y;

  assign if1.in_valid = iv[1];  assign if1.mode = md[1];  assign if1.out_ready = ordy[1];
  assign if1.in_x = ix[1];      assign if1.in_y = iy[1];
  assign ir[1] = if1.in_ready;  assign ov[1] = if1.out_valid;
  assign ox[1] = if1.out_x;     assign oy[1] = if1.out_y;

  assign if2.in_valid = iv[2];  assign if2.mode = md[2];  assign if2.out_ready = ordy[2];
  assign if2.in_x = ix[2][15:0];
  assign if2.in_y = iy[2][15:0];
  assign ir[2] = if2.in_ready;  assign ov[2] = if2.out_valid;
  assign ox[2] = {16'd0, if2.out_x};
  assign oy[2] = {16'd0, if2.out_y};

  speck_cipher_core #(.W(32), .ROUNDS(27), .RPC(1)) dut0 (
    .clk(clk), .rst(rst), .bus(if0), .rk_flat_i(rk32_flat), .busy_o(bz[0]));
  speck_cipher_core #(.W(32), .ROUNDS(27), .RPC(3)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .rk_flat_i(rk32_flat), .busy_o(bz[1]));
  speck_cipher_core #(.W(16), .ROUNDS(22), .RPC(1)) dut2 (
    .clk(clk), .rst(rst), .bus(if2), .rk_flat_i(rk16_flat), .busy_o(bz[2]));

  function automatic logic [63:0] wmask(input int w);
    return (w == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] v, input int s, input int w);
    return ((v >> s) | (v << (w - s))) & wmask(w);
  endfunction

  function automatic logic [63:0] rotl(input logic [63:0] v, input int s, input int w);
    return ((v << s) | (v >> (w - s))) & wmask(w);
  endfunction

  // Speck key expansion for a four-word key (l2 l1 l0 k0), result in ks_rk.
  task automatic key_sched(input int w, input int rounds,
                           input logic [63:0] k0, l0, l1, l2);
    logic [63:0] l [30];
    logic [63:0] k;
    int a, b;
    a = (w == 16) ? 7 : 8;
    b = (w == 16) ? 2 : 3;
    l[0] = l0; l[1] = l1; l[2] = l2;
    k = k0;
    ks_rk[0] = k;
    for (int i = 0; i < rounds - 1; i++) begin
      l[i+3] = ((k + rotr(l[i], a, w)) & wmask(w)) ^ 64'(i);
      k = rotl(k, b, w) ^ l[i+3];
      ks_rk[i+1] = k;
    end
  endtask

  // Reference 64/128 cipher on the current rk32 list; returns {x, y}.
  function automatic logic [63:0] model32(input logic dec, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xv, yv, kk;
    xv = 64'(x); yv = 64'(y);
    for (int r = 0; r < 27; r++) begin
      if (!dec) begin
        kk = 64'(rk32[r]);
        xv = ((rotr(xv, 8, 32) + yv) & wmask(32)) ^ kk;
        yv = rotl(yv, 3, 32) ^ xv;
      end else begin
        kk = 64'(rk32[26 - r]);
        yv = rotr(xv ^ yv, 3, 32);
        xv = rotl(((xv ^ kk) - yv) & wmask(32), 8, 32);
      end
    end
    return {xv[31:0], yv[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction; hold = cycles of backpressure in DONE, early = out_ready high before DONE.
  task automatic run_block(input int sel, input logic m, input logic [31:0] x, input logic [31:0] y,
                           input int hold, input bit early,
                           output logic [31:0] rx, output logic [31:0] ry, output int lat);
    int n;
    n = 0;
    while (!ir[sel] && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_accept", 64'(ir[sel]), 64'd1);
    iv[sel] = 1'b1; md[sel] = m; ix[sel] = x; iy[sel] = y; ordy[sel] = early;
    @(posedge clk); #1;
    iv[sel] = 1'b0; md[sel] = ~m; ix[sel] = $urandom; iy[sel] = $urandom;
    check("busy_after_accept", 64'(bz[sel]), 64'd1);
    check("in_ready_after_accept", 64'(ir[sel]), 64'd0);
    lat = 0;
    while (!ov[sel] && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    rx = ox[sel]; ry = oy[sel];
    for (int c = 0; c < hold; c++) begin
      iv[sel] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("hold_out_x", 64'(ox[sel]), 64'(rx));
      check("hold_out_y", 64'(oy[sel]), 64'(ry));
      check("hold_out_valid", 64'(ov[sel]), 64'd1);
      check("hold_in_ready", 64'(ir[sel]), 64'd0);
    end
    iv[sel] = 1'b0;
    ordy[sel] = 1'b1;
    @(posedge clk); #1;
    ordy[sel] = 1'b0;
    check("out_valid_after_handshake", 64'(ov[sel]), 64'd0);
    check("in_ready_after_handshake", 64'(ir[sel]), 64'd1);
    check("busy_after_handshake", 64'(bz[sel]), 64'd0);
  endtask

  typedef struct {
    int          sel;
    logic        mode;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ex;
    logic [31:0] ey;
    int          lat;
    int          hold;
    bit          early;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [31:0] rx, ry, px, py;
    logic [63:0] exp;
    int lat, rises;

    vecs[0] = '{0, MODE_ENC, 32'h3b726574, 32'h7475432d, 32'h8c6fa548, 32'h454e028b, 27, 0, 1'b0};
    vecs[1] = '{0, MODE_DEC, 32'h8c6fa548, 32'h454e028b, 32'h3b726574, 32'h7475432d, 27, 10, 1'b0};
    vecs[2] = '{1, MODE_ENC, 32'h3b726574, 32'h7475432d, 32'h8c6fa548, 32'h454e028b, 9, 0, 1'b1};
    vecs[3] = '{1, MODE_DEC, 32'h8c6fa548, 32'h454e028b, 32'h3b726574, 32'h7475432d, 9, 3, 1'b0};
    vecs[4] = '{2, MODE_ENC, 32'h00006574, 32'h0000694c, 32'h0000a868, 32'h000042f2, 22, 0, 1'b1};
    vecs[5] = '{2, MODE_DEC, 32'h0000a868, 32'h000042f2, 32'h00006574, 32'h0000694c, 22, 2, 1'b0};

    for (int s = 0; s < 3; s++) begin
      iv[s] = 1'b0; md[s] = 1'b0; ordy[s] = 1'b0; ix[s] = '0; iy[s] = '0;
    end

    key_sched(32, 27, 64'h03020100, 64'h0b0a0908, 64'h13121110, 64'h1b1a1918);
    for (int i = 0; i < 27; i++) rk32[i] = ks_rk[i][31:0];
    key_sched(16, 22, 64'h0100, 64'h0908, 64'h1110, 64'h1918);
    for (int i = 0; i < 22; i++) rk16[i] = ks_rk[i][15:0];

    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check("reset_in_ready", 64'(ir[s]), 64'd0);
      check("reset_out_valid", 64'(ov[s]), 64'd0);
      check("reset_busy", 64'(bz[s]), 64'd0);
      check("reset_out_xy", {ox[s], oy[s]}, 64'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) check("in_ready_after_reset", 64'(ir[s]), 64'd1);

    for (int v = 0; v < 6; v++) begin
      run_block(vecs[v].sel, vecs[v].mode, vecs[v].x, vecs[v].y, vecs[v].hold, vecs[v].early, rx, ry, lat);
      check("vec_out_x", 64'(rx), 64'(vecs[v].ex));
      check("vec_out_y", 64'(ry), 64'(vecs[v].ey));
      check("vec_latency", 64'(lat), 64'(vecs[v].lat));
    end

    // Reset in the middle of a block: result must be dropped.
    iv[0] = 1'b1; md[0] = MODE_ENC; ix[0] = 32'h3b726574; iy[0] = 32'h7475432d;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", 64'(ir[0]), 64'd0);
    check("midrst_busy", 64'(bz[0]), 64'd0);
    check("midrst_out_valid", 64'(ov[0]), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_ready_release", 64'(ir[0]), 64'd1);
    rises = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (ov[0]) rises++;
    end
    check("midrst_no_out_valid", 64'(rises), 64'd0);
    run_block(0, MODE_ENC, 32'h3b726574, 32'h7475432d, 0, 1'b0, rx, ry, lat);
    check("post_rst_x", 64'(rx), 64'h8c6fa548);
    check("post_rst_y", 64'(ry), 64'h454e028b);
    check("post_rst_latency", 64'(lat), 64'd27);

    // Random keys and blocks against the reference model.
    for (int t = 0; t < 3; t++) begin
      key_sched(32, 27, 64'($urandom), 64'($urandom), 64'($urandom), 64'($urandom));
      for (int i = 0; i < 27; i++) rk32[i] = ks_rk[i][31:0];
      px = $urandom; py = $urandom;
      exp = model32(MODE_ENC, px, py);
      for (int s = 0; s < 2; s++) begin
        run_block(s, MODE_ENC, px, py, $urandom_range(0, 3), 1'($urandom_range(0, 1)), rx, ry, lat);
        check("rand_enc", {rx, ry}, exp);
        run_block(s, MODE_DEC, exp[63:32], exp[31:0], $urandom_range(0, 3), 1'b0, rx, ry, lat);
        check("rand_dec", {rx, ry}, {px, py});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
